// File: rtl/aes_bus_sequencer.sv
// aes_bus_sequencer
// Bus master that runs one complete AES block operation on an 8-bit register bus.
// It writes the key (optional) and the data block byte-wise, starts the core,
// polls its status register and reads back the 16 result bytes.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      request pulse, accepted only when idle
//   load_key   sampled with start: 1 = write key, 0 = reuse key already in core
//   key, din   128-bit key / data block, byte i = [127-8i -: 8]
//   busy       high from the cycle after an accepted start through the done cycle
//   done       one-cycle end-of-operation pulse
//   error      poll timeout flag, valid with done, held until next accepted start
//   dout       128-bit result, updated only in the done cycle
//   bus_valid/bus_wen/bus_addr/bus_wdata   register bus request (all registered)
//   bus_rdata  read data, valid the cycle after a read access
module aes_bus_sequencer #(
  parameter logic [7:0]  KEY_BASE   = 8'h00,
  parameter logic [7:0]  DIN_BASE   = 8'h10,
  parameter logic [7:0]  DOUT_BASE  = 8'h20,
  parameter logic [7:0]  CTRL_ADDR  = 8'h30,
  parameter logic [7:0]  STAT_ADDR  = 8'h31,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load_key,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] dout,
  output logic         bus_valid,
  output logic         bus_wen,
  output logic [7:0]   bus_addr,
  output logic [7:0]   bus_wdata,
  input  logic [7:0]   bus_rdata
);

  localparam logic [7:0] POLL_MAX = POLL_LIMIT[7:0];

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_KEY, ST_WR_DIN, ST_WR_CTRL, ST_POLL_REQ,
    ST_POLL_WAIT, ST_RD_REQ, ST_RD_WAIT, ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     poll_q, poll_d;
  logic [127:0]   key_q, key_d, din_q, din_d, res_q, res_d, dout_q, dout_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic           bus_valid_q, bus_valid_d, bus_wen_q, bus_wen_d;
  logic [7:0]     bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;

  // Byte i of a 128-bit word, byte 0 being the most significant.
  function automatic logic [7:0] byte_sel(input logic [127:0] w, input logic [3:0] i);
    byte_sel = w[{4'd15 - i, 3'b000} +: 8];
  endfunction

  // Next-state, counters, staging and registered-output next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    key_d       = key_q;
    din_d       = din_q;
    res_d       = res_q;
    dout_d      = dout_q;
    error_d     = error_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          din_d   = din;
          error_d = 1'b0;
          idx_d   = 4'd0;
          state_d = load_key ? ST_WR_KEY : ST_WR_DIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_KEY: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = ST_WR_DIN;
        end else begin
          state_d = ST_WR_KEY;
        end
      end
      ST_WR_DIN: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          poll_d  = 8'd0;
          state_d = ST_WR_CTRL;
        end else begin
          state_d = ST_WR_DIN;
        end
      end
      ST_WR_CTRL: begin
        state_d = ST_POLL_REQ;
      end
      ST_POLL_REQ: begin
        poll_d  = poll_q + 8'd1;
        state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (bus_rdata[0]) begin
          idx_d   = 4'd0;
          state_d = ST_RD_REQ;
        end else if (poll_q < POLL_MAX) begin
          state_d = ST_POLL_REQ;
        end else begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        res_d[{4'd15 - idx_q, 3'b000} +: 8] = bus_rdata;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so the bus request is visible
    // in the same cycle the state register holds the matching state.
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    bus_valid_d = 1'b0;
    if ((state_d == ST_DONE) && !error_d) begin
      dout_d = res_d;
    end else begin
      dout_d = dout_q;
    end

    case (state_d)
      ST_WR_KEY: begin
        bus_valid_d = 1'b1;
        bus_wen_d   = 1'b1;
        bus_addr_d  = KEY_BASE + {4'd0, idx_d};
        bus_wdata_d = byte_sel(key_d, idx_d);
      end
      ST_WR_DIN: begin
        bus_valid_d = 1'b1;
        bus_wen_d   = 1'b1;
        bus_addr_d  = DIN_BASE + {4'd0, idx_d};
        bus_wdata_d = byte_sel(din_d, idx_d);
      end
      ST_WR_CTRL: begin
        bus_valid_d = 1'b1;
        bus_wen_d   = 1'b1;
        bus_addr_d  = CTRL_ADDR;
        bus_wdata_d = 8'h01;
      end
      ST_POLL_REQ: begin
        bus_valid_d = 1'b1;
        bus_wen_d   = 1'b0;
        bus_addr_d  = STAT_ADDR;
      end
      ST_RD_REQ: begin
        bus_valid_d = 1'b1;
        bus_wen_d   = 1'b0;
        bus_addr_d  = DOUT_BASE + {4'd0, idx_d};
      end
      default: begin
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State, counters, staging and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      poll_q      <= 8'd0;
      key_q       <= 128'd0;
      din_q       <= 128'd0;
      res_q       <= 128'd0;
      dout_q      <= 128'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= 8'd0;
      bus_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      key_q       <= key_d;
      din_q       <= din_d;
      res_q       <= res_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      bus_valid_q <= bus_valid_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dout      = dout_q;
  assign bus_valid = bus_valid_q;
  assign bus_wen   = bus_wen_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
